// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the data memory
// controller (slave).
interface dmem_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Handshaked word-organised data memory with byte-lane stores, extended sub-word
// loads and range/size errors. Define DMEM_MISALIGN_EN to reject misaligned accesses.
module dmem_ctrl #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 1
) (
    input  logic       clk,
    input  logic       rstn,
    dmem_ctrl_if.slave bus
);
    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Shift the addressed lane down to bit 0 and extend it to the full word.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                    input logic [1:0]      lane,
                                                    input logic [1:0]      size,
                                                    input logic            uns);
        logic [XLEN-1:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            2'b01:   load_extend = uns ? {{(XLEN-8){1'b0}}, sh[7:0]}
                                       : {{(XLEN-8){sh[7]}}, sh[7:0]};
            2'b10:   load_extend = uns ? {{(XLEN-16){1'b0}}, sh[15:0]}
                                       : {{(XLEN-16){sh[15]}}, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    logic [XLEN-1:0]  mem_r [DEPTH_WORDS];
    state_e           state_r, state_nxt_s;
    logic [2:0]       cnt_r, cnt_nxt_s;
    logic             req_ready_r, resp_valid_r, resp_err_r, err_nxt_s;
    logic [XLEN-1:0]  resp_rdata_r, rdata_nxt_s;
    logic [XLEN-1:0]  ld_word_r;
    logic [1:0]       ld_lane_r, ld_size_r;
    logic             ld_uns_r;

    logic [IDX_W-1:0] idx_s;
    logic [1:0]       lane_s;
    logic [3:0]       be_s;
    logic             range_err_s, mis_err_s, size_err_s, err_s, accept_s, wr_en_s;
    logic [XLEN-1:0]  wdata_sh_s, rd_word_s;

    assign idx_s       = bus.req_addr[2 +: IDX_W];
    assign range_err_s = |(bus.req_addr >> (IDX_W + 2));
    assign size_err_s  = (bus.req_size == 2'b00);
    assign err_s       = range_err_s | mis_err_s | size_err_s;
    assign accept_s    = bus.req_valid & req_ready_r & (state_r == IDLE);
    assign wr_en_s     = accept_s & bus.req_we & ~err_s;
    assign wdata_sh_s  = bus.req_wdata << {lane_s, 3'b000};
    assign rd_word_s   = mem_r[idx_s];

    // Lane selection, byte enables and alignment check for the offered request.
    always_comb begin
        lane_s    = bus.req_addr[1:0];
        mis_err_s = 1'b0;
        be_s      = 4'b0000;
        case (bus.req_size)
            2'b01: be_s = 4'b0001 << lane_s;
            2'b10: begin
`ifdef DMEM_MISALIGN_EN
                mis_err_s = bus.req_addr[0];
`else
                lane_s    = {bus.req_addr[1], 1'b0};
`endif
                be_s      = 4'b0011 << {bus.req_addr[1], 1'b0};
            end
            2'b11: begin
`ifdef DMEM_MISALIGN_EN
                mis_err_s = (bus.req_addr[1:0] != 2'b00);
`else
                lane_s    = 2'b00;
`endif
                be_s      = 4'b1111;
            end
            default: be_s = 4'b0000;
        endcase
    end

    // Next state, latency counter and next response payload.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rdata_nxt_s = resp_rdata_r;
        err_nxt_s   = resp_err_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_nxt_s = RESP;
                        rdata_nxt_s = '0;
                        err_nxt_s   = 1'b1;
                    end else if (bus.req_we) begin
                        state_nxt_s = RESP;
                        rdata_nxt_s = '0;
                        err_nxt_s   = 1'b0;
                    end else if (RD_LATENCY == 1) begin
                        state_nxt_s = RESP;
                        rdata_nxt_s = load_extend(rd_word_s, lane_s, bus.req_size, bus.req_unsigned);
                        err_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = LAT_M1;
                        err_nxt_s   = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 3'd1) begin
                    state_nxt_s = RESP;
                    rdata_nxt_s = load_extend(ld_word_r, ld_lane_r, ld_size_r, ld_uns_r);
                    err_nxt_s   = 1'b0;
                end else begin
                    cnt_nxt_s   = cnt_r - 3'd1;
                end
            end
            RESP: begin
                if (resp_valid_r & bus.resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Control and response registers; the load word is captured at acceptance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= '0;
            resp_err_r   <= 1'b0;
            ld_word_r    <= '0;
            ld_lane_r    <= 2'b00;
            ld_size_r    <= 2'b00;
            ld_uns_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            req_ready_r  <= (state_nxt_s == IDLE);
            resp_valid_r <= (state_nxt_s == RESP);
            resp_rdata_r <= rdata_nxt_s;
            resp_err_r   <= err_nxt_s;
            if (accept_s && !bus.req_we) begin
                ld_word_r <= rd_word_s;
                ld_lane_r <= lane_s;
                ld_size_r <= bus.req_size;
                ld_uns_r  <= bus.req_unsigned;
            end
        end
    end

    // Byte-enabled store into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: vector table with a response scoreboard,
// plus back-pressure and reset-during-transaction sequences.
module tb_dmem_ctrl;
    localparam int LAT = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dmem_ctrl_if #(.XLEN(32)) bus ();

    dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .RD_LATENCY(LAT)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) timeout({nm, " ready"});
    endtask

    task automatic drive(input vec_t v);
        bus.req_we       = v.we;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_valid    = 1'b1;
    endtask

    // One transaction; hold > 0 keeps resp_ready low for that many cycles.
    task automatic run_req(input vec_t v, input int hold, input string nm);
        exp_t e;
        exp_t got;
        int   n;
        logic [31:0] held;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        e.lat   = (!v.we && !v.exp_err) ? LAT : 1;
        wait_ready(nm);
        drive(v);
        bus.resp_ready = (hold == 0);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        got = sb_q.pop_front();
        if (bus.resp_valid !== 1'b1) begin
            timeout({nm, " resp"});
            return;
        end
        chk({nm, " latency"}, 32'(n), 32'(got.lat));
        chk({nm, " rdata"}, bus.resp_rdata, got.rdata);
        chk({nm, " err"}, 32'(bus.resp_err), 32'(got.err));
        held = bus.resp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, " hold valid"}, 32'(bus.resp_valid), 32'd1);
            chk({nm, " hold rdata"}, bus.resp_rdata, held);
            chk({nm, " hold ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk({nm, " valid drop"}, 32'(bus.resp_valid), 32'd0);
        chk({nm, " ready back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n;

        add(1'b1, 32'h10,   32'h11223344, 2'b11, 1'b0, 32'h0,        1'b0);
        add(1'b0, 32'h10,   32'h0,        2'b11, 1'b0, 32'h11223344, 1'b0);
        add(1'b1, 32'h13,   32'h123456AB, 2'b01, 1'b0, 32'h0,        1'b0);
        add(1'b0, 32'h10,   32'h0,        2'b11, 1'b0, 32'hAB223344, 1'b0);
        add(1'b0, 32'h13,   32'h0,        2'b01, 1'b0, 32'hFFFFFFAB, 1'b0);
        add(1'b0, 32'h13,   32'h0,        2'b01, 1'b1, 32'h000000AB, 1'b0);
        add(1'b1, 32'h20,   32'h55667788, 2'b11, 1'b0, 32'h0,        1'b0);
        add(1'b1, 32'h22,   32'hDEAD8001, 2'b10, 1'b0, 32'h0,        1'b0);
        add(1'b0, 32'h22,   32'h0,        2'b10, 1'b0, 32'hFFFF8001, 1'b0);
        add(1'b0, 32'h22,   32'h0,        2'b10, 1'b1, 32'h00008001, 1'b0);
        add(1'b0, 32'h20,   32'h0,        2'b11, 1'b0, 32'h80017788, 1'b0);
        add(1'b0, 32'h20,   32'h0,        2'b01, 1'b0, 32'hFFFFFF88, 1'b0);
        add(1'b0, 32'h21,   32'h0,        2'b01, 1'b1, 32'h00000077, 1'b0);
        add(1'b0, 32'h1000, 32'h0,        2'b11, 1'b0, 32'h0,        1'b1);
        add(1'b1, 32'h1000, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h0,        1'b1);
        add(1'b0, 32'h10,   32'h0,        2'b00, 1'b0, 32'h0,        1'b1);
        add(1'b1, 32'h14,   32'hCAFEF00D, 2'b11, 1'b0, 32'h0,        1'b0);
`ifdef DMEM_MISALIGN_EN
        add(1'b1, 32'h16,   32'h12345678, 2'b11, 1'b0, 32'h0,        1'b1);
        add(1'b0, 32'h14,   32'h0,        2'b11, 1'b0, 32'hCAFEF00D, 1'b0);
        add(1'b0, 32'h11,   32'h0,        2'b10, 1'b0, 32'h0,        1'b1);
        add(1'b0, 32'h12,   32'h0,        2'b11, 1'b0, 32'h0,        1'b1);
`else
        add(1'b1, 32'h16,   32'h12345678, 2'b11, 1'b0, 32'h0,        1'b0);
        add(1'b0, 32'h14,   32'h0,        2'b11, 1'b0, 32'h12345678, 1'b0);
        add(1'b0, 32'h11,   32'h0,        2'b10, 1'b0, 32'h00003344, 1'b0);
        add(1'b0, 32'h12,   32'h0,        2'b11, 1'b0, 32'hAB223344, 1'b0);
`endif
        add(1'b0, 32'h12,   32'h0,        2'b01, 1'b0, 32'h00000022, 1'b0);

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.resp_ready   = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset resp_rdata", bus.resp_rdata, 32'h0);
        chk("reset resp_err", 32'(bus.resp_err), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("release req_ready", 32'(bus.req_ready), 32'd1);

        foreach (vecs[i]) run_req(vecs[i], 0, $sformatf("vec%0d", i));

        // Back-pressure: response held for five cycles
        v.we = 1'b0; v.addr = 32'h10; v.wdata = 32'h0; v.size = 2'b11; v.uns = 1'b0;
        v.exp_rdata = 32'hAB223344; v.exp_err = 1'b0;
        run_req(v, 5, "hold");

        // Reset while the load sits in WAIT
        wait_ready("rst_wait");
        drive(v);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_wait pre valid", 32'(bus.resp_valid), 32'd0);
        rstn = 1'b0;
        #1;
        chk("rst_wait req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_wait resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_wait ready before edge", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("rst_wait ready after edge", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_wait no stale resp", 32'(bus.resp_valid), 32'd0);
        end

        // Reset while a response is being held
        wait_ready("rst_resp");
        drive(v);
        bus.resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_resp pre valid", 32'(bus.resp_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_resp valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp rdata", bus.resp_rdata, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        bus.resp_ready = 1'b1;
        @(negedge clk);

        // Array contents survive reset
        v.addr = 32'h20; v.exp_rdata = 32'h80017788;
        run_req(v, 0, "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
